// File: rtl/alu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_pkg
// Purpose  : Shared types and constants for the ALU writeback stage.
//            - opcode constants for the flag-affecting arithmetic ops
//            - bit positions of Z/N/C/V inside the 4-bit flags word
//            - packed queue entry carried from the ALU to the register file
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic                 carry;
    logic                 ovf;
    logic [3:0]           opcode;
    logic [WB_REG_AW-1:0] rd;
    logic                 wb_en;
  } wb_entry_t;

  // Only add and sub are allowed to change C/V and the sticky overflow bit.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_fifo2
// Purpose  : Two-entry in-order queue of wb_entry_t. Slot 0 is always the
//            head (oldest); slot 1 holds the second entry when count==2.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            push, push_data  - enqueue request (ignored while full)
//            pop              - dequeue head (ignored while empty)
//            head, second     - registered view of slot 0 / slot 1
//            count            - occupancy 0..2
//            full             - registered, high when count==DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module alu_wb_fifo2
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_entry_t  push_data,
  input  logic       pop,
  output wb_entry_t  head,
  output wb_entry_t  second,
  output logic [1:0] count,
  output logic       full
);

  wb_entry_t  r_mem [0:1];
  logic [1:0] r_count;
  logic       r_full;

  logic       w_push;
  logic       w_pop;
  logic       w_wr_idx;
  logic [1:0] w_count_nxt;

  assign w_pop       = pop && (r_count != 2'd0);
  assign w_push      = push && !r_full;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  // Push lands behind whatever survives this cycle's pop: slot 1 only when
  // one entry is held and it is not leaving.
  assign w_wr_idx    = (r_count != 2'd0) && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count  <= 2'd0;
      r_full   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_mem[0] <= r_mem[1];
      end
      if (w_push) begin
        if (w_wr_idx) begin
          r_mem[1] <= push_data;
        end else begin
          r_mem[0] <= push_data;
        end
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 2'(DEPTH));
    end
  end

  assign head   = r_mem[0];
  assign second = r_mem[1];
  assign count  = r_count;
  assign full   = r_full;

endmodule
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback_stage
// Purpose  : Buffers ALU results in a 2-entry queue and retires them into the
//            register-file write port, maintaining Z/N/C/V flags and a
//            sticky overflow bit.
// Config   : define ALU_WB_FWD_EN to enable the forwarding lookup
//            (fwd_hit/fwd_data); otherwise both are tied to 0.
// Ports    : clk, rst                      - clock, async active-high reset
//            in_valid/in_ready             - ALU-side handshake
//            in_result/carry/overflow/opcode/rd/wb_en - ALU result record
//            rf_ready, rf_we/waddr/wdata   - register-file write port
//            flags {Z,N,C,V}, ovf_sticky, clear_sticky
//            fwd_rs, fwd_hit, fwd_data     - forwarding lookup
// Revision : 1.0 - initial release
// ============================================================================
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [3:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wb_en,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        flags,
  output logic              ovf_sticky,
  input  logic              clear_sticky,
  input  logic [REG_AW-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  wb_entry_t  w_push_data;
  wb_entry_t  w_head;
  wb_entry_t  w_second;
  logic [1:0] w_count;
  logic       w_full;
  logic       w_head_valid;
  logic       w_head_writes;
  logic       w_retire;
  logic       w_head_arith;

  logic [3:0] r_flags;
  logic       r_sticky;

  assign w_push_data.result = in_result;
  assign w_push_data.carry  = in_carry;
  assign w_push_data.ovf    = in_overflow;
  assign w_push_data.opcode = in_opcode;
  assign w_push_data.rd     = in_rd;
  assign w_push_data.wb_en  = in_wb_en;

  alu_wb_fifo2 #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_data(w_push_data),
    .pop      (w_retire),
    .head     (w_head),
    .second   (w_second),
    .count    (w_count),
    .full     (w_full)
  );

  assign in_ready      = !w_full;
  assign w_head_valid  = (w_count != 2'd0);
  // Entries that do not touch the register file never wait for the port.
  assign w_head_writes = w_head.wb_en && (w_head.rd != '0);
  assign w_retire      = w_head_valid && (rf_ready || !w_head_writes);
  assign w_head_arith  = is_arith(w_head.opcode);

  assign rf_we    = w_head_valid && w_head_writes && rf_ready;
  assign rf_waddr = w_head.rd;
  assign rf_wdata = w_head.result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags  <= 4'b0000;
      r_sticky <= 1'b0;
    end else begin
      if (w_retire) begin
        r_flags[FLG_Z] <= (w_head.result == '0);
        r_flags[FLG_N] <= w_head.result[DATA_W-1];
        if (w_head_arith) begin
          r_flags[FLG_C] <= w_head.carry;
          r_flags[FLG_V] <= w_head.ovf;
        end
      end
      // Set has priority over a same-cycle clear.
      if (w_retire && w_head_arith && w_head.ovf) begin
        r_sticky <= 1'b1;
      end else if (clear_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign flags      = r_flags;
  assign ovf_sticky = r_sticky;

`ifdef ALU_WB_FWD_EN
  // Youngest match wins: slot 1 (valid only when two entries are held)
  // is checked before the head.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if ((w_count == 2'd2) && w_second.wb_en && (w_second.rd == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = w_second.result;
      end else if (w_head_valid && w_head.wb_en && (w_head.rd == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = w_head.result;
      end
    end
  end
`else
  logic w_fwd_unused;
  assign w_fwd_unused = ^{fwd_rs, w_second};
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_writeback_stage
// Purpose  : Self-checking bench for alu_writeback_stage. Register-file
//            writes are checked against a queue of expected {rd, data}
//            pushed on accept; flags/sticky are checked from a vector table
//            plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_writeback_stage;
  import alu_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_overflow;
  logic [3:0]  in_opcode;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  flags;
  logic        ovf_sticky;
  logic        clear_sticky;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  alu_writeback_stage #(.DATA_W(32), .REG_AW(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags(flags), .ovf_sticky(ovf_sticky), .clear_sticky(clear_sticky),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        rdy;
    logic        clr;
    logic [3:0]  exp_flags;
    logic        exp_sticky;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs [9];
  wr_t  sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every write the DUT issues must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0d data %h required=no write",
                 rf_waddr, rf_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.a});
        chk("wr_data", rf_wdata, e.d);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] res, input logic c, input logic v,
                      input logic [3:0] op, input logic [4:0] rd, input logic wb,
                      input logic expect_wr);
    int n = 0;
    in_valid = 1'b1; in_result = res; in_carry = c; in_overflow = v;
    in_opcode = op; in_rd = rd; in_wb_en = wb;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=in_ready %b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (expect_wr && wb && rd != 5'd0) sb.push_back('{rd, res});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_carry = 1'b0; in_overflow = 1'b0;
    in_opcode = '0; in_rd = '0; in_wb_en = 1'b0; rf_ready = 1'b1;
    clear_sticky = 1'b0; fwd_rs = '0;

    //          res           c     v     op      rd     wb    rdy   clr   flags    sticky
    vecs[0] = '{32'h8000_0000, 1'b0, 1'b1, OP_ADD, 5'd5,  1'b1, 1'b1, 1'b0, 4'b0101, 1'b1};
    vecs[1] = '{32'h0000_0000, 1'b0, 1'b0, 4'h0,   5'd6,  1'b1, 1'b1, 1'b1, 4'b1001, 1'b0};
    vecs[2] = '{32'h0000_0005, 1'b1, 1'b0, OP_SUB, 5'd7,  1'b1, 1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, 4'h0,   5'd8,  1'b1, 1'b1, 1'b0, 4'b1010, 1'b0};
    vecs[4] = '{32'h0000_0007, 1'b0, 1'b0, 4'h0,   5'd0,  1'b1, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 1'b1, OP_ADD, 5'd9,  1'b0, 1'b0, 1'b0, 4'b0111, 1'b1};
    vecs[6] = '{32'h0000_0001, 1'b0, 1'b1, OP_SUB, 5'd10, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 4'h5,   5'd31, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1};
    vecs[8] = '{32'h8000_0000, 1'b0, 1'b0, 4'h1,   5'd1,  1'b1, 1'b1, 1'b1, 4'b0101, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_sticky", {31'd0, ovf_sticky}, 32'd0);

    // Single-entry vectors: accept, retire one cycle later, check state.
    for (int i = 0; i < 9; i++) begin
      rf_ready = vecs[i].rdy;
      push(vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].wb, 1'b1);
      clear_sticky = vecs[i].clr;
      @(posedge clk); #1;
      clear_sticky = 1'b0;
      chk($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].exp_flags});
      chk($sformatf("vec%0d_sticky", i), {31'd0, ovf_sticky}, {31'd0, vecs[i].exp_sticky});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    rf_ready = 1'b1;
    drain("vec_drain");

    // Backpressure: two accepts fill the queue, third is held by upstream.
    rf_ready = 1'b0;
    push(32'hA1, 1'b0, 1'b0, 4'h0, 5'd11, 1'b1, 1'b1);
    push(32'hA2, 1'b0, 1'b0, 4'h0, 5'd12, 1'b1, 1'b1);
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_result = 32'hA3; in_carry = 1'b0; in_overflow = 1'b0;
    in_opcode = 4'h0; in_rd = 5'd13; in_wb_en = 1'b1;
    sb.push_back('{5'd13, 32'hA3});
    repeat (2) @(posedge clk);
    #1;
    chk("bp_still_low", {31'd0, in_ready}, 32'd0);
    chk("bp_no_write", sb.size(), 3);
    rf_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_retire_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp_three_cycles", sb.size(), 0);

    // Reset mid-stream: sticky set, two writes pending, then reset.
    rf_ready = 1'b0;
    push(32'h8000_0000, 1'b0, 1'b1, OP_ADD, 5'd2, 1'b0, 1'b0);
    push(32'hB1, 1'b0, 1'b0, 4'h0, 5'd14, 1'b1, 1'b0);
    push(32'hB2, 1'b0, 1'b0, 4'h0, 5'd15, 1'b1, 1'b0);
    chk("pre_reset_sticky", {31'd0, ovf_sticky}, 32'd1);
    rst = 1'b1;
    #1 rf_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_reset_flags", {28'd0, flags}, 32'd0);
    chk("mid_reset_sticky", {31'd0, ovf_sticky}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // rd=0 retires without the write port, flags from reset state.
    rf_ready = 1'b0;
    push(32'd7, 1'b0, 1'b0, 4'h0, 5'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rd0_flags", {28'd0, flags}, 32'd0);
    chk("rd0_in_ready", {31'd0, in_ready}, 32'd1);

    // Same-cycle sticky set and clear: set wins.
    rf_ready = 1'b1;
    push(32'd1, 1'b0, 1'b1, OP_ADD, 5'd3, 1'b1, 1'b1);
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    chk("set_wins_sticky", {31'd0, ovf_sticky}, 32'd1);
    chk("set_wins_flags", {28'd0, flags}, 32'b0001);

    // Back-to-back stream: accept and retire in the same cycle, no bubble.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream%0d_ready", i), {31'd0, in_ready}, 32'd1);
      push(32'hC0 + i, 1'b0, 1'b0, 4'h2, 5'(16 + i), 1'b1, 1'b1);
    end
    drain("stream_drain");

    // Forwarding lookup with two pending writes to the same register.
    rf_ready = 1'b0;
    push(32'd11, 1'b0, 1'b0, 4'h0, 5'd3, 1'b1, 1'b1);
    push(32'd22, 1'b0, 1'b0, 4'h0, 5'd3, 1'b1, 1'b1);
    fwd_rs = 5'd3;
    #1;
`ifdef ALU_WB_FWD_EN
    chk("fwd_hit_rd3", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_data_youngest", fwd_data, 32'd22);
    fwd_rs = 5'd0;
    #1;
    chk("fwd_rs0_miss", {31'd0, fwd_hit}, 32'd0);
    fwd_rs = 5'd9;
    #1;
    chk("fwd_rs9_miss", {31'd0, fwd_hit}, 32'd0);
`else
    chk("fwd_off_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fwd_off_data", fwd_data, 32'd0);
`endif
    fwd_rs = 5'd0;
    @(posedge clk); #1;
    rf_ready = 1'b1;
    drain("fwd_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the 32-bit ALU.
- Buffers ALU results in a 2-entry in-order queue with a valid/ready handshake.
- Retires entries into the register-file write port when the port is free.
- Maintains the architectural Z/N/C/V flags and a sticky overflow bit.

Parameters:
- DATA_W, 32, result width; must match ALU result width.
- REG_AW, 5, register-file address width.
- DEPTH, 2, queue entries; only 2 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  stage can accept; registered, equals !full.
- in_result  in  DATA_W  ALU result.
- in_carry  in  1  ALU carry_out.
- in_overflow  in  1  ALU overflow.
- in_opcode  in  4  ALU opcode that produced the result.
- in_rd  in  REG_AW  destination register.
- in_wb_en  in  1  1 means write the result to the register file.
- rf_ready  in  1  register-file write port available this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- flags  out  4  {Z,N,C,V}, registered.
- ovf_sticky  out  1  sticky overflow.
- clear_sticky  in  1  clears ovf_sticky.
- fwd_rs  in  REG_AW  forwarding lookup address (see Optional Feature).
- fwd_hit  out  1  pending entry matches fwd_rs.
- fwd_data  out  DATA_W  data of matching entry.

Behaviour:
- Reset: queue emptied, count=0, in_ready=1, rf_we=0, flags=4'b0000, ovf_sticky=0. Reset mid-operation discards all pending entries; nothing is written.
- Accept: in_valid && in_ready captures {result, carry, overflow, opcode, rd, wb_en} at the tail.
- Occupancy and ready: count ranges 0..2. in_ready is registered and low only when count==2. in_valid while in_ready=0 is ignored, and upstream must hold it.
- Retire eligibility (head valid): eligible when rf_ready=1, or when wb_en=0, or when rd==0. Retire pops the head the same cycle.
- Register-file outputs are combinational from the registered head:
  - rf_we = head_valid && wb_en && rd!=0 && rf_ready.
  - rf_waddr = head rd; rf_wdata = head result.
- Latency: an entry accepted in cycle t reaches the head and can retire in cycle t+1 at the earliest.
- Simultaneous accept and retire:
  - count=1: count stays 1 and the new entry becomes the head.
  - count=2: no accept (ready=0); retire brings count to 1, and in_ready rises the next cycle.
- Flags, updated only on retire:
  - Z = (result==0); N = result[DATA_W-1].
  - C and V load carry/overflow only for opcode 4'b0011 (add) or 4'b0100 (sub); otherwise C and V hold.
  - Flags update even when rf_we is suppressed (rd==0 or wb_en=0).
- ovf_sticky: set on retire of an add/sub entry with overflow=1. clear_sticky clears it. Same-cycle set and clear: set wins.
- Ordering: strictly in order; no entry is dropped or duplicated.

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined: fwd_hit = 1 when any valid entry with wb_en=1 and rd==fwd_rs, where fwd_rs!=0. fwd_data comes from the youngest matching entry (the tail has priority over the head). The lookup is purely combinational from registered state.
- Undefined: fwd_hit tied 0, fwd_data tied 0, and fwd_rs is unused. Upstream then stalls on hazards.

Decomposition:
- Package alu_wb_pkg holds:
  - opcode constants OP_ADD=4'b0011, OP_SUB=4'b0100.
  - flag bit indices FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0.
  - packed entry typedef wb_entry_t {result, carry, ovf, opcode, rd, wb_en}.
- Sub-module alu_wb_fifo2: 2-entry queue of wb_entry_t with push/pop, head/tail view, count and full.
- The top level holds retire logic, the flag register, the sticky bit and forwarding.

Test Plan:
- Reset mid-stream: push 2 entries, assert rst -> rf_we never pulses, flags=0000, in_ready=1 after reset.
- Add overflow: result=32'h8000_0000, overflow=1, carry=0, opcode=0011, rd=5, wb_en=1, rf_ready=1 -> rf_we pulse with waddr=5, wdata=80000000; flags=0101 (N,V); ovf_sticky=1.
- Backpressure: rf_ready=0, push 3 entries -> third held, in_ready=0 after 2 accepts. Then rf_ready=1 -> retire in order over 3 cycles with no loss.
- Logic op after sub carry: sub with carry=1, then AND with result=0 and opcode 0000 -> flags=1010 (Z, C held, V from sub=0).
- rd=0 write: result=7, rd=0, rf_ready=0 -> retires without stall, rf_we=0, flags=0000. Then same-cycle clear_sticky with an overflow set -> ovf_sticky=1.
- With ALU_WB_FWD_EN: entries rd=3 data=11, then rd=3 data=22 pending, fwd_rs=3 -> fwd_hit=1, fwd_data=22. With fwd_rs=0 -> fwd_hit=0.
